subfil_tapctl: RTL and testbench
================================

SUBFIL_TAPCTL -- requirements
Module: subfil_tapctl

Interface
REQ-001 SHALL have parameter IW, default 16, sample width in bits.
REQ-002 SHALL have parameter TW, default 12, coefficient width in bits.
REQ-003 SHALL have parameter LGNTAPS, default 10; NTAPS = 2^LGNTAPS taps per bank.
REQ-004 SHALL have parameter LGNBANKS, default 2; NBANKS = 2^LGNBANKS coefficient banks.
REQ-005 SHALL have ports: i_clk in 1, sole clock; i_reset in 1, asynchronous active-high reset.
REQ-006 SHALL have ports: i_cfg_we in 1, bank-memory write strobe; i_cfg_addr in LGNBANKS+LGNTAPS, {bank,tap} address; i_cfg_data in TW, coefficient.
REQ-007 SHALL have ports: i_load in 1, reload request; i_bank in LGNBANKS, bank to load; o_busy out 1, reload in progress; o_bank out LGNBANKS, bank last loaded; o_loaded out 1, a full load has completed since reset.
REQ-008 SHALL have ports: i_ce in 1, sample strobe; i_sample in IW, sample; o_fil_ce out 1, strobe to filter; o_fil_sample out IW, sample to filter; o_dropped out 1, one-cycle pulse per rejected i_ce.
REQ-009 SHALL have ports: o_fil_reset out 1, filter reset pulse; o_wr_tap out 1, tap write strobe; o_tap out TW, tap value.

Function
REQ-010 SHALL hold an NBANKS*NTAPS x TW memory, written at i_cfg_addr on any cycle i_cfg_we=1, in every state; contents are not reset.
REQ-011 SHALL read bank memory synchronously; same-cycle read/write of one address returns the old value.
REQ-012 SHALL implement states RUN, DRAIN, CLEAR, LOAD.
REQ-013 SHALL have a gap counter loaded with NTAPS+4 on each cycle a sample is forwarded, else decremented, saturating at 0.
REQ-014 In RUN, i_ce=1 with gap counter 0 SHALL give o_fil_ce=1 and o_fil_sample=i_sample on the next cycle (1-cycle latency).
REQ-015 In RUN with gap counter nonzero, or in any non-RUN state, i_ce=1 SHALL give o_dropped=1 on the next cycle, no o_fil_ce.
REQ-016 Forwarded samples SHALL therefore be at least NTAPS+5 cycles apart.
REQ-017 o_fil_sample SHALL hold its value between forwarded samples.
REQ-018 In RUN, i_load=1 SHALL capture i_bank, set o_busy=1 next cycle, and move to DRAIN; i_load is ignored in all other states.
REQ-019 Simultaneous i_load and acceptable i_ce in RUN SHALL forward the sample and also begin the reload.
REQ-020 DRAIN SHALL remain until gap counter is 0, then move to CLEAR.
REQ-021 CLEAR SHALL last one cycle, assert o_fil_reset for exactly that cycle, and issue the read of tap 0 of the captured bank.
REQ-022 LOAD SHALL last exactly NTAPS cycles; on its k-th cycle (k=0..NTAPS-1), o_wr_tap=1 and o_tap = captured-bank tap k, with no gaps.
REQ-023 After the last LOAD cycle, the block SHALL enter RUN, set o_busy=0, o_wr_tap=0, o_bank=captured bank, and o_loaded=1, all on the same cycle.
REQ-024 The gap counter SHALL be 0 on LOAD exit, so the first i_ce after the reload is accepted.
REQ-025 A cfg write to the captured bank during LOAD SHALL affect only taps not yet read.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 On i_reset: state RUN, gap counter 0, o_busy 0, o_bank 0, o_loaded 0, o_fil_ce 0, o_fil_sample 0, o_dropped 0, o_fil_reset 0, o_wr_tap 0, o_tap 0.
REQ-028 Reset asserted mid-LOAD or mid-DRAIN SHALL abort immediately, with no further o_wr_tap; o_bank and o_loaded take their reset values.
REQ-029 The first i_ce after reset release SHALL be accepted.

Verification (LGNTAPS=3, NTAPS=8, LGNBANKS=2)
REQ-030 Pacing: i_ce at cycles 0, 5 and 13 in RUN -> o_fil_ce at cycles 1 and 14; o_dropped at cycle 6.
REQ-031 Reload: write bank 2 taps 0x010..0x017, then i_load with i_bank=2 and no samples -> o_fil_reset for 1 cycle, then 8 consecutive o_wr_tap with o_tap 0x010..0x017, then o_busy=0, o_bank=2, o_loaded=1.
REQ-032 Drain: sample forwarded at cycle 0, i_load at cycle 2 -> CLEAR no earlier than cycle 13; i_ce during DRAIN/CLEAR/LOAD -> o_dropped each time, o_fil_ce never.
REQ-033 Mid-load write: during LOAD of bank 1 at tap 2, write bank 1 tap 6 = 0xABC -> 7th o_wr_tap carries 0xABC.
REQ-034 Reset mid-LOAD after 3 writes -> o_wr_tap=0 immediately, o_busy=0, o_loaded=0; a subsequent i_ce is accepted.
REQ-035 i_load while o_busy=1 with a different bank -> ignored; o_bank ends as the originally captured bank.

Source files
------------

// File: rtl/subfil_tapctl.sv
// Coefficient-bank controller for a serial FIR: paces samples into the filter and,
// on request, drains the filter, resets it and streams one stored bank into its taps.
module subfil_tapctl #(
    parameter int IW       = 16,
    parameter int TW       = 12,
    parameter int LGNTAPS  = 10,
    parameter int LGNBANKS = 2
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_cfg_we,
    input  logic [LGNBANKS+LGNTAPS-1:0]  i_cfg_addr,
    input  logic [TW-1:0]                i_cfg_data,
    input  logic                         i_load,
    input  logic [LGNBANKS-1:0]          i_bank,
    output logic                         o_busy,
    output logic [LGNBANKS-1:0]          o_bank,
    output logic                         o_loaded,
    input  logic                         i_ce,
    input  logic [IW-1:0]                i_sample,
    output logic                         o_fil_ce,
    output logic [IW-1:0]                o_fil_sample,
    output logic                         o_dropped,
    output logic                         o_fil_reset,
    output logic                         o_wr_tap,
    output logic [TW-1:0]                o_tap
);

    localparam int NTAPS  = 1 << LGNTAPS;
    localparam int NBANKS = 1 << LGNBANKS;
    localparam int AW     = LGNBANKS + LGNTAPS;
    localparam int GW     = LGNTAPS + 2;
    localparam logic [GW-1:0] GAP_INIT = GW'(NTAPS + 4);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_CLEAR,
        S_LOAD
    } state_t;

    state_t                state, state_nx;
    logic [GW-1:0]         gap, gap_nx;
    logic [LGNBANKS-1:0]   cap_bank, cap_bank_nx;
    logic [LGNTAPS-1:0]    tap_idx, tap_idx_nx;
    logic                  rd_en;
    logic [LGNTAPS-1:0]    rd_tap;
    logic                  accept;

    logic                  busy_nx, loaded_nx, fil_ce_nx, dropped_nx;
    logic                  fil_reset_nx, wr_tap_nx;
    logic [LGNBANKS-1:0]   bank_nx;
    logic [IW-1:0]         fil_sample_nx;

    logic [TW-1:0]         mem [NBANKS*NTAPS];

    // Coefficient store: writable at any time, never reset.
    always_ff @(posedge i_clk) begin
        if (i_cfg_we)
            mem[i_cfg_addr] <= i_cfg_data;
    end

    // The read register is o_tap itself; the read is issued one cycle ahead of
    // the tap strobe (tap 0 from CLEAR, tap k+1 from LOAD cycle k).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            o_tap <= '0;
        else if (rd_en)
            o_tap <= mem[AW'({cap_bank, rd_tap})];
    end

    always_comb begin
        state_nx      = state;
        cap_bank_nx   = cap_bank;
        tap_idx_nx    = tap_idx;
        bank_nx       = o_bank;
        loaded_nx     = o_loaded;
        rd_en         = 1'b0;
        rd_tap        = '0;

        accept        = i_ce && (state == S_RUN) && (gap == '0);
        fil_ce_nx     = accept;
        dropped_nx    = i_ce && !accept;
        fil_sample_nx = accept ? i_sample : o_fil_sample;
        gap_nx        = accept ? GAP_INIT
                      : (gap == '0) ? '0 : gap - GW'(1);

        case (state)
            S_RUN: begin
                if (i_load) begin
                    cap_bank_nx = i_bank;
                    state_nx    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (gap == '0)
                    state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                state_nx   = S_LOAD;
                tap_idx_nx = '0;
                rd_en      = 1'b1;
                rd_tap     = '0;
            end
            S_LOAD: begin
                if (tap_idx == '1) begin
                    state_nx  = S_RUN;
                    bank_nx   = cap_bank;
                    loaded_nx = 1'b1;
                end else begin
                    tap_idx_nx = tap_idx + LGNTAPS'(1);
                    rd_en      = 1'b1;
                    rd_tap     = tap_idx + LGNTAPS'(1);
                end
            end
            default: state_nx = S_RUN;
        endcase

        // Status strobes follow the next state so they line up with it once registered.
        busy_nx      = (state_nx != S_RUN);
        fil_reset_nx = (state_nx == S_CLEAR);
        wr_tap_nx    = (state_nx == S_LOAD);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= S_RUN;
            gap          <= '0;
            cap_bank     <= '0;
            tap_idx      <= '0;
            o_busy       <= 1'b0;
            o_bank       <= '0;
            o_loaded     <= 1'b0;
            o_fil_ce     <= 1'b0;
            o_fil_sample <= '0;
            o_dropped    <= 1'b0;
            o_fil_reset  <= 1'b0;
            o_wr_tap     <= 1'b0;
        end else begin
            state        <= state_nx;
            gap          <= gap_nx;
            cap_bank     <= cap_bank_nx;
            tap_idx      <= tap_idx_nx;
            o_busy       <= busy_nx;
            o_bank       <= bank_nx;
            o_loaded     <= loaded_nx;
            o_fil_ce     <= fil_ce_nx;
            o_fil_sample <= fil_sample_nx;
            o_dropped    <= dropped_nx;
            o_fil_reset  <= fil_reset_nx;
            o_wr_tap     <= wr_tap_nx;
        end
    end

endmodule

// File: tb/tb_subfil_tapctl.sv
// Directed bench for subfil_tapctl with 8 taps and 4 banks: pacing, reload,
// drain timing, mid-load coefficient write, ignored reload and reset mid-load.
module tb_subfil_tapctl;

    localparam int IW = 16, TW = 12, LGNTAPS = 3, LGNBANKS = 2, NTAPS = 8;

    logic                        i_clk = 1'b0;
    logic                        i_reset;
    logic                        i_cfg_we;
    logic [LGNBANKS+LGNTAPS-1:0] i_cfg_addr;
    logic [TW-1:0]               i_cfg_data;
    logic                        i_load;
    logic [LGNBANKS-1:0]         i_bank;
    logic                        o_busy;
    logic [LGNBANKS-1:0]         o_bank;
    logic                        o_loaded;
    logic                        i_ce;
    logic [IW-1:0]               i_sample;
    logic                        o_fil_ce;
    logic [IW-1:0]               o_fil_sample;
    logic                        o_dropped;
    logic                        o_fil_reset;
    logic                        o_wr_tap;
    logic [TW-1:0]               o_tap;

    subfil_tapctl #(.IW(IW), .TW(TW), .LGNTAPS(LGNTAPS), .LGNBANKS(LGNBANKS)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
        .i_load(i_load), .i_bank(i_bank), .o_busy(o_busy), .o_bank(o_bank),
        .o_loaded(o_loaded), .i_ce(i_ce), .i_sample(i_sample),
        .o_fil_ce(o_fil_ce), .o_fil_sample(o_fil_sample), .o_dropped(o_dropped),
        .o_fil_reset(o_fil_reset), .o_wr_tap(o_wr_tap), .o_tap(o_tap)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs set before a tick are sampled at its edge; outputs are read 1 ns later.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic cfg_write(input int bank, input int tap, input int val);
        i_cfg_we   = 1'b1;
        i_cfg_addr = 5'(bank * NTAPS + tap);
        i_cfg_data = 12'(val);
        tick();
        i_cfg_we   = 1'b0;
    endtask

    logic [15:0] exp_samp;
    logic [31:0] exp_tap;
    logic        want_ce, want_drop;
    int          clear_c;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        i_reset = 1'b1; i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_data = '0;
        i_load = 1'b0; i_bank = '0; i_ce = 1'b0; i_sample = '0;
        repeat (2) tick();

        check("rst_busy",      32'(o_busy),       0);
        check("rst_bank",      32'(o_bank),       0);
        check("rst_loaded",    32'(o_loaded),     0);
        check("rst_fil_ce",    32'(o_fil_ce),     0);
        check("rst_fil_samp",  32'(o_fil_sample), 0);
        check("rst_dropped",   32'(o_dropped),    0);
        check("rst_fil_reset", 32'(o_fil_reset),  0);
        check("rst_wr_tap",    32'(o_wr_tap),     0);
        check("rst_tap",       32'(o_tap),        0);
        i_reset = 1'b0;

        // Pacing: i_ce at 0, 5, 13 -> forwarded at 1 and 14, dropped at 6.
        exp_samp = '0;
        for (int c = 0; c <= 14; c++) begin
            i_ce     = (c == 0 || c == 5 || c == 13);
            i_sample = 16'(32'h1000 + c);
            tick();
            want_ce   = (c == 0 || c == 13);
            want_drop = (c == 5);
            if (want_ce) exp_samp = 16'(32'h1000 + c);
            check($sformatf("pace_ce_c%0d", c + 1),   32'(o_fil_ce),     32'(want_ce));
            check($sformatf("pace_drop_c%0d", c + 1), 32'(o_dropped),    32'(want_drop));
            check($sformatf("pace_samp_c%0d", c + 1), 32'(o_fil_sample), 32'(exp_samp));
        end
        i_ce = 1'b0;
        repeat (16) tick();

        for (int k = 0; k < NTAPS; k++) begin
            cfg_write(2, k, 'h010 + k);
            cfg_write(1, k, 'h100 + k);
        end

        // Reload of bank 2 with an idle filter: DRAIN exits at once.
        i_load = 1'b1; i_bank = 2'd2;
        tick();
        i_load = 1'b0;
        check("rl_busy_set", 32'(o_busy),   1);
        check("rl_loaded0",  32'(o_loaded), 0);
        clear_c = -1;
        for (int c = 1; c < 40; c++) begin
            tick();
            if (o_fil_reset) begin clear_c = c; break; end
        end
        check("rl_clear_cycle", 32'(clear_c), 1);
        check("rl_clear_nowr",  32'(o_wr_tap), 0);
        for (int k = 0; k < NTAPS; k++) begin
            tick();
            check($sformatf("rl_wr_%0d", k),   32'(o_wr_tap),    1);
            check($sformatf("rl_tap_%0d", k),  32'(o_tap),       32'('h010 + k));
            check($sformatf("rl_frst_%0d", k), 32'(o_fil_reset), 0);
        end
        tick();
        check("rl_done_busy",   32'(o_busy),   0);
        check("rl_done_wr",     32'(o_wr_tap), 0);
        check("rl_done_bank",   32'(o_bank),   2);
        check("rl_done_loaded", 32'(o_loaded), 1);

        // Drain: sample at 0, load of bank 1 at 2, CLEAR lands in cycle 14.
        i_ce = 1'b1; i_sample = 16'h2222;
        tick();
        i_ce = 1'b0;
        check("dr_first_ce", 32'(o_fil_ce), 1);
        tick();
        i_load = 1'b1; i_bank = 2'd1;
        tick();
        i_load = 1'b0;
        check("dr_busy",  32'(o_busy),    1);
        check("dr_drop0", 32'(o_dropped), 0);
        i_ce = 1'b1; i_sample = 16'h5A5A;
        clear_c = -1;
        for (int c = 3; c < 40; c++) begin
            tick();
            check($sformatf("dr_drop_c%0d", c + 1), 32'(o_dropped), 1);
            check($sformatf("dr_ce_c%0d", c + 1),   32'(o_fil_ce),  0);
            if (o_fil_reset) begin clear_c = c; break; end
        end
        check("dr_clear_cycle", 32'(clear_c), 13);
        check("dr_samp_hold",   32'(o_fil_sample), 32'h2222);

        // LOAD of bank 1: overwrite tap 6 while tap 2 is out, and try a reload of bank 3.
        for (int k = 0; k < NTAPS; k++) begin
            tick();
            exp_tap = (k == 6) ? 32'hABC : 32'('h100 + k);
            check($sformatf("ld_wr_%0d", k),   32'(o_wr_tap),  1);
            check($sformatf("ld_tap_%0d", k),  32'(o_tap),     exp_tap);
            check($sformatf("ld_drop_%0d", k), 32'(o_dropped), 1);
            check($sformatf("ld_ce_%0d", k),   32'(o_fil_ce),  0);
            if (k == 2) begin
                i_cfg_we = 1'b1; i_cfg_addr = 5'(1 * NTAPS + 6); i_cfg_data = 12'hABC;
                i_load = 1'b1; i_bank = 2'd3;
            end else begin
                i_cfg_we = 1'b0; i_load = 1'b0;
            end
        end
        i_cfg_we = 1'b0; i_load = 1'b0;
        tick();
        check("ld_done_busy",   32'(o_busy),    0);
        check("ld_done_wr",     32'(o_wr_tap),  0);
        check("ld_done_bank",   32'(o_bank),    1);
        check("ld_done_loaded", 32'(o_loaded),  1);
        check("ld_done_drop",   32'(o_dropped), 1);
        tick();
        i_ce = 1'b0;
        check("post_ld_ce",   32'(o_fil_ce),     1);
        check("post_ld_samp", 32'(o_fil_sample), 32'h5A5A);

        // Reset during LOAD after three tap writes.
        repeat (16) tick();
        i_load = 1'b1; i_bank = 2'd2;
        tick();
        i_load = 1'b0;
        clear_c = -1;
        for (int c = 1; c < 40; c++) begin
            tick();
            if (o_fil_reset) begin clear_c = c; break; end
        end
        check("rm_clear_cycle", 32'(clear_c), 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rm_wr_%0d", k), 32'(o_wr_tap), 1);
        end
        #2;
        i_reset = 1'b1;
        #1;
        check("rm_wr_async",     32'(o_wr_tap),    0);
        check("rm_busy_async",   32'(o_busy),      0);
        check("rm_loaded_async", 32'(o_loaded),    0);
        check("rm_bank_async",   32'(o_bank),      0);
        check("rm_tap_async",    32'(o_tap),       0);
        tick();
        check("rm_wr_held", 32'(o_wr_tap), 0);
        i_reset = 1'b0;
        i_ce = 1'b1; i_sample = 16'h7777;
        tick();
        i_ce = 1'b0;
        check("rm_ce_after",   32'(o_fil_ce),     1);
        check("rm_samp_after", 32'(o_fil_sample), 32'h7777);
        check("rm_busy_after", 32'(o_busy),       0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rm_wr_after_%0d", k), 32'(o_wr_tap), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
